surround_scanner: RTL and testbench
===================================

Name: surround_scanner

Overview:
- Upstream sequencer for the servo PWM stage; drives its 4-bit position code `minsg` (0 = park, 1..5 = sweep sectors).
- Sweeps sectors 1 to 5 in order. At each sector it waits for the servo to settle, fires one ultrasonic ranging pulse and measures the echo width.
- After a full sweep it reports the nearest-obstacle sector and its distance for the steering logic.

Parameters:
- SETTLE_CYC, 2000000: clock cycles to wait after a position change before triggering.
- TRIG_CYC, 500: TRIG high width in cycles.
- DIV_CYC, 2900: clock cycles of echo-high per distance unit.
- TIMEOUT_CYC, 1500000: maximum cycles spent in WAIT_ECHO or in MEASURE.
- DIST_W, 10: width of distance values.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RST  in  1  asynchronous, active-high reset.
- EN  in  1  level enable; high = sweep continuously, low = park.
- ECHO  in  1  ultrasonic echo, asynchronous; double-flop synchronised inside.
- TRIG  out  1  ultrasonic trigger pulse.
- minsg  out  4  servo position code to the PWM stage.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse when a sweep completes.
- best_sg  out  4  sector (1..5) with the smallest distance from the last completed sweep.
- min_dist  out  DIST_W  distance at best_sg.

Behaviour:
- Reset values:
  - TRIG=0, minsg=0, busy=0, done=0, best_sg=0, min_dist=all ones.
  - State IDLE; all counters 0.
- Echo input: ECHO passes through 2 flops; edges are detected on the synchronised signal. Add 2 cycles of input latency.
- States:
  - IDLE: minsg=0. When EN=1, set sec=1, minsg=1, busy=1, clear the scratch minimum to all ones, go to SETTLE.
  - SETTLE: count SETTLE_CYC cycles, then go to TRIG.
  - TRIG: TRIG=1 for exactly TRIG_CYC cycles, then go to WAIT_ECHO.
  - WAIT_ECHO: on a synchronised rising edge, go to MEASURE with the distance counter at 0.
    - If TIMEOUT_CYC elapses first, dist = all ones; go to NEXT.
  - MEASURE: a prescaler counts to DIV_CYC. On each wrap, dist increments, saturating at all ones.
    - On a synchronised falling edge, go to NEXT.
    - If TIMEOUT_CYC elapses, dist = all ones; go to NEXT.
  - NEXT (1 cycle): if dist < scratch_min, set scratch_min = dist and scratch_sg = sec.
    - Ties keep the earlier (lower) sector.
    - If sec==5, go to REPORT. Otherwise sec++, minsg = sec+1, go to SETTLE.
  - REPORT (1 cycle): copy best_sg/min_dist from scratch, done=1, busy=0.
    - If EN=1, restart directly as for IDLE (sec=1, minsg=1). Otherwise go to IDLE.
- Output timing:
  - minsg changes only on state entry into SETTLE or IDLE; it is stable for the whole settle and measure window.
  - best_sg/min_dist update only in REPORT and hold between sweeps.
- All-timeout sweep: scratch_min stays all ones and the strict `<` never fires, so scratch_sg keeps its initial value 1. REPORT gives best_sg=1, min_dist=all ones. The "scratch_sg initialised to 1" rule is part of the spec.
- EN falling mid-sweep (any state except REPORT): next cycle go to IDLE.
  - TRIG=0, minsg=0, busy=0, no done pulse.
  - Scratch results are discarded; best_sg/min_dist keep their previous values.
- ECHO already high on entry to WAIT_ECHO: no rising edge is seen, so the sector times out. No false measurement.
- RST asserted at any time: immediate return to reset values, including mid-TRIG (TRIG drops asynchronously).
- Counters:
  - Settle/trig/timeout share one counter, sized with $clog2 of the largest parameter; it is cleared on every state entry.
  - Prescaler width is $clog2(DIV_CYC).

Decomposition:
- Shared package surround_pkg:
  - state enum (IDLE, SETTLE, TRIG, WAIT_ECHO, MEASURE, NEXT, REPORT)
  - constants SG_PARK=0, SG_FIRST=1, SG_LAST=5
- One sub-module, echo_timer: ECHO synchroniser, edge detect, prescaler and saturating distance counter.
  - Controls: start/clear.
  - Outputs: rise, fall, dist.
- Sweep FSM and minimum tracking stay in surround_scanner.

Test Plan:
All scenarios use SETTLE_CYC=20, TRIG_CYC=10, DIV_CYC=4, TIMEOUT_CYC=400, DIST_W=8.
1. Reset then EN=1, echo widths 40/80/12/60/100 cycles for sectors 1..5 -> minsg steps 1,2,3,4,5; TRIG high exactly 10 cycles each; done pulse once; best_sg=3, min_dist=3 (12/4, ±1 for sync).
2. Equal echoes of 40 cycles on sectors 2 and 4, longer elsewhere -> best_sg=2, min_dist=10.
3. ECHO never rises on any sector -> each sector takes 400 cycles in WAIT_ECHO; best_sg=1, min_dist=255.
4. Echo held high 2000 cycles on sector 1 -> MEASURE exits at 400 cycles with dist=255 (saturated/timeout); sweep continues to sector 2.
5. EN dropped during sector 3 MEASURE -> next cycle minsg=0, busy=0, TRIG=0, no done; best_sg/min_dist equal the prior sweep's values.
6. RST pulsed while TRIG=1 -> TRIG=0 immediately, minsg=0, min_dist=255, state IDLE; with EN=1, a new sweep starts at minsg=1 after RST releases.

Source files
------------

// File: rtl/surround_pkg.sv
// rtl/surround_pkg.sv - shared state type, sector codes and helpers for the surround scanner
package surround_pkg;

    // Sweep sequencer states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_TRIG,
        ST_WAIT_ECHO,
        ST_MEASURE,
        ST_NEXT,
        ST_REPORT
    } state_e;

    // Servo position codes
    localparam logic [3:0] SG_PARK  = 4'd0;
    localparam logic [3:0] SG_FIRST = 4'd1;
    localparam logic [3:0] SG_LAST  = 4'd5;

    // Largest of three cycle counts, used to size the shared phase counter
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/surround_scanner_echo_timer.sv
// rtl/surround_scanner_echo_timer.sv - echo synchroniser, edge detect and prescaled distance counter
module echo_timer #(
    parameter int DIV_CYC = 2900,
    parameter int DIST_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              echo_i,
    input  logic              clear_i,
    input  logic              run_i,
    output logic              rise_o,
    output logic              fall_o,
    output logic [DIST_W-1:0] dist_o
);

    localparam int               PRE_W    = (DIV_CYC > 1) ? $clog2(DIV_CYC) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV_CYC - 1);

    // sync_q[0]/[1] are the two synchroniser flops, sync_q[2] holds the previous synced level
    logic [2:0] sync_q;

    logic [PRE_W-1:0]  pre_q;
    logic [PRE_W-1:0]  pre_d;
    logic [DIST_W-1:0] dist_q;
    logic [DIST_W-1:0] dist_d;

    // Shift the raw echo through the synchroniser and edge-history flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], echo_i};
        end
    end

    assign rise_o = sync_q[1] & ~sync_q[2];
    assign fall_o = ~sync_q[1] & sync_q[2];

    // Prescaler wraps every DIV_CYC run cycles; each wrap adds one saturating distance unit
    always_comb begin
        pre_d  = pre_q;
        dist_d = dist_q;
        if (clear_i) begin
            pre_d  = '0;
            dist_d = '0;
        end else if (run_i) begin
            if (pre_q == PRE_LAST) begin
                pre_d = '0;
                if (dist_q != '1) begin
                    dist_d = dist_q + DIST_W'(1);
                end
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end
    end

    // Prescaler and distance registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q  <= '0;
            dist_q <= '0;
        end else begin
            pre_q  <= pre_d;
            dist_q <= dist_d;
        end
    end

    assign dist_o = dist_q;

endmodule

// File: rtl/surround_scanner.sv
// rtl/surround_scanner.sv - five-sector servo sweep with ultrasonic ranging and nearest-sector report
module surround_scanner #(
    parameter int SETTLE_CYC  = 2000000,
    parameter int TRIG_CYC    = 500,
    parameter int DIV_CYC     = 2900,
    parameter int TIMEOUT_CYC = 1500000,
    parameter int DIST_W      = 10
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              ECHO,
    output logic              TRIG,
    output logic [3:0]        minsg,
    output logic              busy,
    output logic              done,
    output logic [3:0]        best_sg,
    output logic [DIST_W-1:0] min_dist
);

    import surround_pkg::*;

    localparam int               CNT_MAX      = max3(SETTLE_CYC, TRIG_CYC, TIMEOUT_CYC);
    localparam int               CNT_W        = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_e            state_q,    state_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic [3:0]        minsg_q,    minsg_d;     // doubles as the current sector during a sweep
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
    logic [3:0]        best_sg_q,  best_sg_d;
    logic [DIST_W-1:0] min_dist_q, min_dist_d;
    logic [DIST_W-1:0] smin_q,     smin_d;      // scratch minimum for the sweep in progress
    logic [3:0]        ssg_q,      ssg_d;       // sector holding the scratch minimum
    logic              tmo_q,      tmo_d;       // current sector ended by timeout

    logic              echo_rise;
    logic              echo_fall;
    logic [DIST_W-1:0] echo_dist;
    logic              meas_run;
    logic [DIST_W-1:0] meas_dist;
    logic              better;
    logic [DIST_W-1:0] new_min;
    logic [3:0]        new_sg;

    assign meas_run = (state_q == ST_MEASURE);

    echo_timer #(
        .DIV_CYC (DIV_CYC),
        .DIST_W  (DIST_W)
    ) u_echo_timer (
        .clk     (CLK),
        .rst     (RST),
        .echo_i  (ECHO),
        .clear_i (~meas_run),
        .run_i   (meas_run),
        .rise_o  (echo_rise),
        .fall_o  (echo_fall),
        .dist_o  (echo_dist)
    );

    // Fold the finished sector into the scratch minimum; strict compare keeps the lower sector on ties
    always_comb begin
        meas_dist = tmo_q ? '1 : echo_dist;
        better    = (meas_dist < smin_q);
        new_min   = better ? meas_dist : smin_q;
        new_sg    = better ? minsg_q : ssg_q;
    end

    // Sweep sequencer: next state, counters, scratch tracking and outputs
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        minsg_d    = minsg_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        best_sg_d  = best_sg_q;
        min_dist_d = min_dist_q;
        smin_d     = smin_q;
        ssg_d      = ssg_q;
        tmo_d      = tmo_q;

        case (state_q)
            ST_IDLE: begin
                if (EN) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                    minsg_d = SG_FIRST;
                    busy_d  = 1'b1;
                    smin_d  = '1;
                    ssg_d   = SG_FIRST;
                    tmo_d   = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_TRIG;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_TRIG: begin
                if (cnt_q == TRIG_LAST) begin
                    state_d = ST_WAIT_ECHO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_ECHO: begin
                if (echo_rise) begin
                    state_d = ST_MEASURE;
                    cnt_d   = '0;
                    tmo_d   = 1'b0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = ST_NEXT;
                    cnt_d   = '0;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_MEASURE: begin
                if (echo_fall) begin
                    state_d = ST_NEXT;
                    cnt_d   = '0;
                    tmo_d   = 1'b0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = ST_NEXT;
                    cnt_d   = '0;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_NEXT: begin
                smin_d = new_min;
                ssg_d  = new_sg;
                cnt_d  = '0;
                tmo_d  = 1'b0;
                if (minsg_q == SG_LAST) begin
                    // Results become visible during the REPORT cycle together with done
                    state_d    = ST_REPORT;
                    best_sg_d  = new_sg;
                    min_dist_d = new_min;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                end else begin
                    state_d = ST_SETTLE;
                    minsg_d = minsg_q + 4'd1;
                end
            end
            ST_REPORT: begin
                cnt_d = '0;
                if (EN) begin
                    state_d = ST_SETTLE;
                    minsg_d = SG_FIRST;
                    busy_d  = 1'b1;
                    smin_d  = '1;
                    ssg_d   = SG_FIRST;
                    tmo_d   = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                    minsg_d = SG_PARK;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                minsg_d = SG_PARK;
                busy_d  = 1'b0;
            end
        endcase

        // Losing EN mid-sweep abandons the sweep without touching the published result
        if (!EN && (state_q != ST_IDLE) && (state_q != ST_REPORT)) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            minsg_d    = SG_PARK;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            best_sg_d  = best_sg_q;
            min_dist_d = min_dist_q;
            tmo_d      = 1'b0;
        end
    end

    // Sequencer and result registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            minsg_q    <= SG_PARK;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            best_sg_q  <= SG_PARK;
            min_dist_q <= '1;
            smin_q     <= '1;
            ssg_q      <= SG_FIRST;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            minsg_q    <= minsg_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            best_sg_q  <= best_sg_d;
            min_dist_q <= min_dist_d;
            smin_q     <= smin_d;
            ssg_q      <= ssg_d;
            tmo_q      <= tmo_d;
        end
    end

    // TRIG decodes straight from the state register so reset drops it without waiting for a clock
    assign TRIG     = (state_q == ST_TRIG);
    assign minsg    = minsg_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign best_sg  = best_sg_q;
    assign min_dist = min_dist_q;

endmodule

// File: tb/tb_surround_scanner.sv
// tb/tb_surround_scanner.sv - self-checking bench for surround_scanner
module tb_surround_scanner;

    localparam int S_CYC  = 20;
    localparam int T_CYC  = 10;
    localparam int D_CYC  = 4;
    localparam int TO_CYC = 400;
    localparam int DW     = 8;
    localparam int DMAX   = 255;
    localparam int SECTOR_CYC = S_CYC + T_CYC + TO_CYC + 1;

    logic          CLK;
    logic          RST;
    logic          EN;
    logic          ECHO;
    logic          TRIG;
    logic [3:0]    minsg;
    logic          busy;
    logic          done;
    logic [3:0]    best_sg;
    logic [DW-1:0] min_dist;

    int total = 0;
    int bad   = 0;

    int echo_w [0:5];
    int echo_dly = 1;

    int cyc = 0;
    int trig_run = 0;
    int done_cnt = 0;
    int last_minsg = 0;
    int trig_q[$];
    int trig_fall_q[$];
    int minsg_q[$];
    int minsg_cyc_q[$];

    surround_scanner #(
        .SETTLE_CYC  (S_CYC),
        .TRIG_CYC    (T_CYC),
        .DIV_CYC     (D_CYC),
        .TIMEOUT_CYC (TO_CYC),
        .DIST_W      (DW)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .EN       (EN),
        .ECHO     (ECHO),
        .TRIG     (TRIG),
        .minsg    (minsg),
        .busy     (busy),
        .done     (done),
        .best_sg  (best_sg),
        .min_dist (min_dist)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Observe TRIG pulse widths, position steps and done pulses
    always @(negedge CLK) begin
        if (TRIG) begin
            trig_run++;
        end else if (trig_run != 0) begin
            trig_q.push_back(trig_run);
            trig_fall_q.push_back(cyc);
            trig_run = 0;
        end
        if (int'(minsg) != last_minsg) begin
            minsg_q.push_back(int'(minsg));
            minsg_cyc_q.push_back(cyc);
            last_minsg = int'(minsg);
        end
        if (done) done_cnt++;
    end

    // Ultrasonic sensor: after each trigger, answer with the echo width set for that sector
    initial begin
        int w;
        ECHO = 1'b0;
        forever begin
            @(negedge TRIG);
            w = (int'(minsg) <= 5) ? echo_w[int'(minsg)] : 0;
            if (w > 0) begin
                repeat (echo_dly) @(negedge CLK);
                ECHO = 1'b1;
                repeat (w) @(negedge CLK);
                ECHO = 1'b0;
            end
        end
    end

    // Reference: distance unit count for an echo of w cycles (0 = no echo)
    function automatic int exp_dist(input int w);
        if (w <= 0 || w >= TO_CYC) return DMAX;
        if (w / D_CYC > DMAX) return DMAX;
        return w / D_CYC;
    endfunction

    // Reference: nearest sector, first one wins on ties, sector 1 if nothing is closer than max
    task automatic model_sweep(output int bsg, output int bmin);
        int d;
        bmin = DMAX;
        bsg  = 1;
        for (int s = 1; s <= 5; s++) begin
            d = exp_dist(echo_w[s]);
            if (d < bmin) begin
                bmin = d;
                bsg  = s;
            end
        end
    endtask

    task automatic clear_obs();
        trig_q.delete();
        trig_fall_q.delete();
        minsg_q.delete();
        minsg_cyc_q.delete();
    endtask

    task automatic wait_done(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge CLK);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Run one full sweep with EN, stop at its REPORT cycle, check the published result
    task automatic do_sweep(input string name, output int start_cyc, output int done_cyc);
        bit ok;
        int bsg, bmin;
        model_sweep(bsg, bmin);
        @(negedge CLK);
        start_cyc = cyc;
        EN = 1'b1;
        wait_done(6000, ok);
        done_cyc = cyc;
        EN = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s_done_timeout: got no done, expected done within 6000 cycles", name);
        end
        repeat (3) @(negedge CLK);
        total++;
        if (int'(best_sg) !== bsg) begin
            bad++;
            $display("FAIL %s_best_sg: got %0d expected %0d", name, best_sg, bsg);
        end
        total++;
        if (int'(min_dist) !== bmin) begin
            bad++;
            $display("FAIL %s_min_dist: got %0d expected %0d", name, min_dist, bmin);
        end
        total++;
        if (busy !== 1'b0 || minsg !== 4'd0) begin
            bad++;
            $display("FAIL %s_parked: got busy=%0b minsg=%0d expected busy=0 minsg=0", name, busy, minsg);
        end
    endtask

    task automatic set_widths(input int w1, input int w2, input int w3, input int w4, input int w5);
        echo_w[0] = 0;
        echo_w[1] = w1;
        echo_w[2] = w2;
        echo_w[3] = w3;
        echo_w[4] = w4;
        echo_w[5] = w5;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        EN  = 1'b0;
        set_widths(0, 0, 0, 0, 0);
        repeat (3) @(negedge CLK);
        total++;
        if (TRIG !== 1'b0 || minsg !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got trig=%0b minsg=%0d busy=%0b done=%0b expected all 0", TRIG, minsg, busy, done);
        end
        total++;
        if (best_sg !== 4'd0 || int'(min_dist) !== DMAX) begin
            bad++;
            $display("FAIL reset_result: got best_sg=%0d min_dist=%0d expected 0/%0d", best_sg, min_dist, DMAX);
        end
        RST = 1'b0;
        repeat (5) @(negedge CLK);
        total++;
        if (minsg !== 4'd0 || busy !== 1'b0 || TRIG !== 1'b0) begin
            bad++;
            $display("FAIL idle_with_en_low: got minsg=%0d busy=%0b trig=%0b expected 0/0/0", minsg, busy, TRIG);
        end
    endtask

    task automatic test_basic_sweep();
        int s0, s1, d0;
        set_widths(40, 80, 12, 60, 100);
        clear_obs();
        d0 = done_cnt;
        do_sweep("basic", s0, s1);
        total++;
        if (minsg_q.size() < 5) begin
            bad++;
            $display("FAIL basic_minsg_steps: got %0d steps expected at least 5", minsg_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (minsg_q[i] !== i + 1) begin
                    bad++;
                    $display("FAIL basic_minsg_seq[%0d]: got %0d expected %0d", i, minsg_q[i], i + 1);
                end
            end
        end
        total++;
        if (trig_q.size() !== 5) begin
            bad++;
            $display("FAIL basic_trig_count: got %0d expected 5", trig_q.size());
        end
        foreach (trig_q[i]) begin
            total++;
            if (trig_q[i] !== T_CYC) begin
                bad++;
                $display("FAIL basic_trig_width[%0d]: got %0d expected %0d", i, trig_q[i], T_CYC);
            end
        end
        total++;
        if (done_cnt - d0 !== 1) begin
            bad++;
            $display("FAIL basic_done_pulses: got %0d expected 1", done_cnt - d0);
        end
    endtask

    task automatic test_tie();
        int s0, s1;
        set_widths(100, 40, 120, 40, 90);
        do_sweep("tie", s0, s1);
    endtask

    task automatic test_no_echo();
        int s0, s1;
        set_widths(0, 0, 0, 0, 0);
        clear_obs();
        do_sweep("no_echo", s0, s1);
        total++;
        if (s1 - s0 !== 1 + 5 * SECTOR_CYC) begin
            bad++;
            $display("FAIL no_echo_sweep_len: got %0d expected %0d", s1 - s0, 1 + 5 * SECTOR_CYC);
        end
        for (int i = 1; i < 5 && i < minsg_cyc_q.size(); i++) begin
            total++;
            if (minsg_cyc_q[i] - minsg_cyc_q[i-1] !== SECTOR_CYC) begin
                bad++;
                $display("FAIL no_echo_sector_len[%0d]: got %0d expected %0d", i, minsg_cyc_q[i] - minsg_cyc_q[i-1], SECTOR_CYC);
            end
        end
    endtask

    task automatic test_long_echo();
        int s0, s1;
        set_widths(2000, 0, 0, 0, 0);
        echo_dly = 1;
        clear_obs();
        do_sweep("long_echo", s0, s1);
        total++;
        if (trig_fall_q.size() < 1 || minsg_cyc_q.size() < 2) begin
            bad++;
            $display("FAIL long_echo_events: got trig=%0d steps=%0d expected >=1 and >=2", trig_fall_q.size(), minsg_cyc_q.size());
        end else if (minsg_cyc_q[1] - trig_fall_q[0] !== echo_dly + 2 + TO_CYC + 1) begin
            bad++;
            $display("FAIL long_echo_measure_len: got %0d expected %0d", minsg_cyc_q[1] - trig_fall_q[0], echo_dly + 2 + TO_CYC + 1);
        end
        total++;
        if (minsg_q.size() < 2 || minsg_q[1] !== 2) begin
            bad++;
            $display("FAIL long_echo_continue: got %0d steps expected step to sector 2", minsg_q.size());
        end
        repeat (20) @(negedge CLK);
    endtask

    task automatic test_random();
        int s0, s1, d0;
        for (int n = 0; n < 3; n++) begin
            echo_w[0] = 0;
            for (int s = 1; s <= 5; s++) begin
                echo_w[s] = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(4, 300));
            end
            echo_dly = int'($urandom_range(1, 5));
            d0 = done_cnt;
            do_sweep("random", s0, s1);
            total++;
            if (done_cnt - d0 !== 1) begin
                bad++;
                $display("FAIL random_done_pulses: got %0d expected 1", done_cnt - d0);
            end
        end
        echo_dly = 1;
    endtask

    task automatic test_back_to_back();
        bit ok;
        int bsg, bmin, d0;
        set_widths(60, 24, 90, 200, 8);
        model_sweep(bsg, bmin);
        d0 = done_cnt;
        @(negedge CLK);
        EN = 1'b1;
        wait_done(6000, ok);
        total++;
        if (!ok || int'(best_sg) !== bsg || int'(min_dist) !== bmin) begin
            bad++;
            $display("FAIL b2b_first: got ok=%0b best=%0d dist=%0d expected 1/%0d/%0d", ok, best_sg, min_dist, bsg, bmin);
        end
        set_widths(150, 150, 150, 150, 44);
        @(negedge CLK);
        total++;
        if (minsg !== 4'd1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_restart: got minsg=%0d busy=%0b expected 1/1", minsg, busy);
        end
        model_sweep(bsg, bmin);
        wait_done(6000, ok);
        EN = 1'b0;
        repeat (3) @(negedge CLK);
        total++;
        if (!ok || int'(best_sg) !== bsg || int'(min_dist) !== bmin) begin
            bad++;
            $display("FAIL b2b_second: got ok=%0b best=%0d dist=%0d expected 1/%0d/%0d", ok, best_sg, min_dist, bsg, bmin);
        end
        total++;
        if (done_cnt - d0 !== 2) begin
            bad++;
            $display("FAIL b2b_done_pulses: got %0d expected 2", done_cnt - d0);
        end
    endtask

    task automatic test_en_drop();
        int s0, s1, pbsg, pbmin, d0;
        bit hit;
        set_widths(90, 30, 70, 50, 110);
        model_sweep(pbsg, pbmin);
        do_sweep("en_drop_prior", s0, s1);
        set_widths(50, 60, 200, 70, 80);
        d0 = done_cnt;
        @(negedge CLK);
        EN = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge CLK);
            if (minsg == 4'd3 && ECHO) begin
                hit = 1'b1;
                break;
            end
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL en_drop_reach_s3: got no sector 3 echo expected one within 5000 cycles");
        end
        repeat (20) @(negedge CLK);
        EN = 1'b0;
        @(negedge CLK);
        total++;
        if (minsg !== 4'd0 || busy !== 1'b0 || TRIG !== 1'b0) begin
            bad++;
            $display("FAIL en_drop_park: got minsg=%0d busy=%0b trig=%0b expected 0/0/0", minsg, busy, TRIG);
        end
        repeat (30) @(negedge CLK);
        total++;
        if (done_cnt !== d0) begin
            bad++;
            $display("FAIL en_drop_no_done: got %0d pulses expected 0", done_cnt - d0);
        end
        total++;
        if (int'(best_sg) !== pbsg || int'(min_dist) !== pbmin) begin
            bad++;
            $display("FAIL en_drop_hold: got best=%0d dist=%0d expected %0d/%0d", best_sg, min_dist, pbsg, pbmin);
        end
        repeat (250) @(negedge CLK);
    endtask

    task automatic test_rst_mid_trig();
        bit hit;
        set_widths(0, 0, 0, 0, 0);
        @(negedge CLK);
        EN = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (TRIG) begin
                hit = 1'b1;
                break;
            end
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL rst_trig_seen: got no TRIG expected one within 100 cycles");
        end
        repeat (3) @(negedge CLK);
        #2;
        RST = 1'b1;
        #1;
        total++;
        if (TRIG !== 1'b0 || minsg !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL rst_async_ctrl: got trig=%0b minsg=%0d busy=%0b done=%0b expected all 0", TRIG, minsg, busy, done);
        end
        total++;
        if (best_sg !== 4'd0 || int'(min_dist) !== DMAX) begin
            bad++;
            $display("FAIL rst_async_result: got best=%0d dist=%0d expected 0/%0d", best_sg, min_dist, DMAX);
        end
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        total++;
        if (minsg !== 4'd1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL rst_restart: got minsg=%0d busy=%0b expected 1/1", minsg, busy);
        end
        EN = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    initial begin
        RST = 1'b1;
        EN  = 1'b0;
        test_reset();
        test_basic_sweep();
        test_tie();
        test_no_echo();
        test_long_echo();
        test_random();
        test_back_to_back();
        test_en_drop();
        test_rst_mid_trig();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
